pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_ctrl.sv | 86 ++++++++
 tb/tb_pc_fetch_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// PC fetch controller: BOOT/RUN/FLUSH sequencing, branch redirect, stall hold and a saturating accept counter.
// Optional macro PC_WRAP_HALT_EN: an accept at pc=31 enters HALT instead of wrapping to 0.
module pc_fetch_ctrl #(
    parameter logic [4:0] RESET_PC = 5'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       branch_taken,
    input  logic [4:0] branch_target,
    input  logic       fetch_ready,
    output logic [4:0] pc,
    output logic [4:0] pc_plus1,
    output logic       fetch_valid,
    output logic       halted,
    output logic [7:0] fetch_count
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
`ifdef PC_WRAP_HALT_EN
    localparam logic [1:0] ST_HALT  = 2'd3;
`endif

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [4:0] pc_nxt;
    logic [7:0] count_nxt;
    logic       accept;
    logic       redirect;

    assign pc_plus1    = pc + 5'd1;
    assign fetch_valid = (state == ST_RUN);
    assign accept      = fetch_valid && fetch_ready && !stall && !branch_taken;

`ifdef PC_WRAP_HALT_EN
    assign halted   = (state == ST_HALT);
    assign redirect = branch_taken && (state != ST_HALT);
`else
    assign halted   = 1'b0;
    assign redirect = branch_taken;
`endif

    always_comb begin
        // NOTE: defaults first so every path assigns every output; this keeps the block latch-free.
        state_nxt = state;
        pc_nxt    = pc;
        if (redirect) begin
            // A redirect beats stall, accept, wrap and halt in the same cycle.
            state_nxt = ST_FLUSH;
            pc_nxt    = branch_target;
        end else begin
            case (state)
                ST_BOOT, ST_FLUSH: state_nxt = ST_RUN;
                ST_RUN: begin
                    if (accept) begin
`ifdef PC_WRAP_HALT_EN
                        if (pc == 5'd31) state_nxt = ST_HALT;
                        else             pc_nxt    = pc_plus1;
`else
                        pc_nxt = pc_plus1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign count_nxt = (accept && (fetch_count != 8'hFF)) ? fetch_count + 8'd1 : fetch_count;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
        if (rst) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            fetch_count <= 8'd0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            fetch_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: stimulus pushes expected post-edge outputs, a negedge monitor pops and compares.
module tb_pc_fetch_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       branch_taken = 1'b0;
    logic [4:0] branch_target = 5'd0;
    logic       fetch_ready = 1'b0;
    logic [4:0] pc;
    logic [4:0] pc_plus1;
    logic       fetch_valid;
    logic       halted;
    logic [7:0] fetch_count;

    typedef struct {
        int         due;
        logic [4:0] pc;
        logic       valid;
        logic [7:0] cnt;
        logic       halted;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    pc_fetch_ctrl #(.RESET_PC(5'd0)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .fetch_ready  (fetch_ready),
        .pc           (pc),
        .pc_plus1     (pc_plus1),
        .fetch_valid  (fetch_valid),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that falls due at this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due == cyc) begin
            exp_t       e;
            logic [4:0] e_p1;
            e    = q.pop_front();
            e_p1 = e.pc + 5'd1;
            vectors++;
            if (pc !== e.pc || pc_plus1 !== e_p1 || fetch_valid !== e.valid ||
                fetch_count !== e.cnt || halted !== e.halted) begin
                miscompares++;
                $display("FAIL %s: got pc=%0d pc_plus1=%0d valid=%0b count=%0d halted=%0b, want pc=%0d pc_plus1=%0d valid=%0b count=%0d halted=%0b",
                         e.name, pc, pc_plus1, fetch_valid, fetch_count, halted,
                         e.pc, e_p1, e.valid, e.cnt, e.halted);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the coming edge.
    task automatic step(input logic r, input logic s, input logic b, input logic [4:0] t,
                        input logic rd, input logic [4:0] epc, input logic ev,
                        input logic [7:0] ec, input logic eh, input string nm);
        exp_t e;
        rst           = r;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        fetch_ready   = rd;
        e.due    = cyc + 1;
        e.pc     = epc;
        e.valid  = ev;
        e.cnt    = ec;
        e.halted = eh;
        e.name   = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [4:0] mpc;
        logic       mvalid;
        logic [7:0] mcnt;
        int         acc;

        //    rst s b tgt rdy  pc v cnt h
        step(1, 0, 0, 0, 0,   0, 0, 0, 0, "reset_state");
        step(0, 0, 0, 0, 1,   0, 1, 0, 0, "boot_to_run");
        step(0, 0, 0, 0, 1,   1, 1, 1, 0, "accept_pc0");
        step(0, 0, 0, 0, 1,   2, 1, 2, 0, "accept_pc1");
        step(0, 0, 0, 0, 1,   3, 1, 3, 0, "accept_pc2");
        step(0, 0, 0, 0, 1,   4, 1, 4, 0, "accept_pc3");
        step(0, 0, 0, 0, 1,   5, 1, 5, 0, "accept_pc4");
        step(0, 1, 0, 0, 1,   5, 1, 5, 0, "stall_1");
        step(0, 1, 0, 0, 1,   5, 1, 5, 0, "stall_2");
        step(0, 1, 0, 0, 1,   5, 1, 5, 0, "stall_3");
        step(0, 0, 0, 0, 1,   6, 1, 6, 0, "accept_pc5");
        step(0, 0, 0, 0, 1,   7, 1, 7, 0, "accept_pc6");
        step(0, 1, 1, 20, 1, 20, 0, 7, 0, "branch_over_stall");
        step(0, 0, 0, 0, 1,  20, 1, 7, 0, "flush_to_run");
        step(0, 0, 0, 0, 1,  21, 1, 8, 0, "accept_pc20");
        step(0, 0, 1, 10, 1, 10, 0, 8, 0, "branch_10");
        step(0, 0, 1, 12, 1, 12, 0, 8, 0, "branch_12_in_flush");
        step(0, 0, 0, 0, 1,  12, 1, 8, 0, "run_after_b2b");
        step(0, 0, 1, 30, 1, 30, 0, 8, 0, "branch_beats_accept");
        step(0, 0, 0, 0, 0,  30, 1, 8, 0, "flush_to_run_30");
        step(0, 0, 0, 0, 0,  30, 1, 8, 0, "not_ready_hold");
        step(0, 0, 0, 0, 1,  31, 1, 9, 0, "accept_pc30");
        step(0, 0, 1, 31, 1, 31, 0, 9, 0, "branch_beats_wrap");
        step(0, 0, 0, 0, 1,  31, 1, 9, 0, "run_at_31");
`ifdef PC_WRAP_HALT_EN
        step(0, 0, 0, 0, 1,  31, 0, 10, 1, "halt_at_31");
        step(0, 0, 1, 5, 1,  31, 0, 10, 1, "halt_ignores_branch");
`else
        step(0, 0, 0, 0, 1,   0, 1, 10, 0, "wrap_31_to_0");
        step(0, 0, 1, 5, 1,   5, 0, 10, 0, "branch_after_wrap");
`endif
        step(1, 1, 1, 9, 1,   0, 0, 0, 0, "reset_overrides");
        step(0, 0, 0, 0, 1,   0, 1, 0, 0, "run_after_reset");

        // Long accept run; steer away from pc=31 with a branch so both builds count identically.
        mpc = 5'd0; mvalid = 1'b1; mcnt = 8'd0; acc = 0;
        while (acc < 300) begin
            if (mvalid && mpc == 5'd31) begin
                mpc = 5'd0; mvalid = 1'b0;
                step(0, 0, 1, 0, 1, mpc, mvalid, mcnt, 0, "sat_redirect");
            end else if (!mvalid) begin
                mvalid = 1'b1;
                step(0, 0, 0, 0, 1, mpc, mvalid, mcnt, 0, "sat_refill");
            end else begin
                mpc = mpc + 5'd1;
                if (mcnt != 8'hFF) mcnt = mcnt + 8'd1;
                acc++;
                step(0, 0, 0, 0, 1, mpc, mvalid, mcnt, 0, "sat_accept");
            end
        end

        fetch_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
